fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch sequencer that sits between the 8-bit program counter and the instruction memory.
- Consumes the PC's count value and sends back its load/up_down/data controls, so it alone decides when the PC holds, advances or jumps.
- Fetches one instruction word per PC value over a req/ack memory handshake and presents it to the decoder through a valid/ready instruction register.
- Branch redirects are taken from the execute stage; an in-flight fetch is drained and discarded.

Parameters:
- ADDR_W, 8, PC/memory address width; must match PC count width.
- INSTR_W, 16, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- run  input  1  fetch enable; 0 parks the block in IDLE after the current instruction completes.
- pc_in  input  ADDR_W  current PC count.
- pc_load  output  1  to PC load.
- pc_up  output  1  to PC up_down.
- pc_data  output  ADDR_W  to PC data.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  memory read address.
- mem_ack  input  1  read data valid, single-cycle pulse.
- mem_rdata  input  INSTR_W  read data, sampled when mem_ack=1.
- ir_valid  output  1  instruction register holds a valid word.
- ir_ready  input  1  decoder accepts the word.
- ir_data  output  INSTR_W  fetched instruction.
- ir_addr  output  ADDR_W  address the instruction was fetched from.
- br_valid  input  1  redirect request, single-cycle.
- br_target  input  ADDR_W  redirect address.

Behaviour:
- PC control (combinational) is chosen by the first matching rule:
  - br_valid=1: pc_load=1, pc_data=br_target.
  - Advance (FETCH state with mem_ack=1): pc_load=0, pc_up=1.
  - Otherwise hold: pc_load=1, pc_data=pc_in.
- The PC has no enable, so the hold rule must be driven in every cycle that is not an advance or a branch.
- States: IDLE, FETCH, DRAIN, VALID. Reset value is IDLE.
- Reset values:
  - mem_req=0, ir_valid=0, ir_data=0, ir_addr=0, internal addr_q=0.
  - PC controls are in hold.
  - Reset asserted mid-operation aborts at once: an outstanding memory request is dropped and the memory side must tolerate this.
- IDLE:
  - mem_req=0.
  - run=1 -> FETCH.
  - br_valid loads the PC and the block stays IDLE.
- FETCH:
  - mem_req=1, mem_addr=pc_in. pc_in is stable because hold is driven.
  - addr_q<=pc_in every cycle.
  - mem_ack=1 without br_valid: ir_data<=mem_rdata, ir_addr<=pc_in, ir_valid<=1, PC advances this cycle, -> VALID.
  - Latency: ir_valid rises on the clock edge after the ack cycle.
- VALID:
  - ir_valid=1; ir_data and ir_addr are held stable until accepted.
  - ir_ready=1: ir_valid<=0; -> FETCH if run=1, else IDLE.
  - ir_ready=0: stay in VALID, no memory activity.
- Branch (br_valid=1) overrides everything except reset:
  - In FETCH with mem_ack=0: -> DRAIN. mem_req stays high with mem_addr=addr_q.
  - In FETCH with mem_ack=1: the data is discarded, the PC advance is suppressed, -> FETCH at the new target.
  - In VALID: ir_valid<=0 even if ir_ready=1 in the same cycle. The word counts as accepted by the decoder. -> FETCH if run=1, else IDLE.
- DRAIN:
  - mem_req=1, mem_addr=addr_q.
  - On mem_ack the data is discarded; -> FETCH if run=1, else IDLE.
  - br_valid during DRAIN loads the PC again and the block stays in DRAIN.
- Handshake rules:
  - mem_req, once raised, stays high with a stable mem_addr until mem_ack.
  - No new request is issued in the cycle an ack is received.
- run=0 never truncates a transaction; it only blocks the next FETCH entry.
- Address 0xFF is fetched normally; the PC's wrap to 0x00 is not special-cased.
- Throughput: at most one instruction per 2 cycles (FETCH+ack, VALID+ready).

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, VALID=2'd3;
  - ADDR_W and INSTR_W defaults.
- Single module. A sub-module is not warranted; the PC stays a separate instance wired to pc_load, pc_up and pc_data.

Test Plan:
- Reset then run=1, memory acks 2 cycles after req with data 0x1234 at address 0x00 -> mem_addr=0x00; ir_valid rises with ir_data=0x1234, ir_addr=0x00; PC reads 0x01 on the cycle after the ack.
- ir_ready held 0 for 5 cycles in VALID -> ir_data stable, mem_req=0, PC held (pc_load=1, pc_data=pc_in).
- br_valid with br_target=0x40 while FETCH awaits an ack -> DRAIN; stale ack data is not presented; the next request has mem_addr=0x40.
- br_valid in the same cycle as mem_ack -> data discarded, PC=target (not +1), ir_valid stays 0.
- PC preset to 0xFF, fetch completes -> ir_addr=0xFF, next mem_addr=0x00.
- reset_n pulled low mid-FETCH -> mem_req and ir_valid drop asynchronously; after release the block is IDLE until run=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default address/instruction widths.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: steers the external PC (hold/advance/load),
// fetches one word per PC value over req/ack and presents it via valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_load,
  output logic               pc_up,
  output logic [ADDR_W-1:0]  pc_data,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_addr,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [ADDR_W-1:0]    r_addr_q;
  logic                 r_ir_valid;
  logic                 w_ir_valid_nxt;
  logic [INSTR_W-1:0]   r_ir_data;
  logic [ADDR_W-1:0]    r_ir_addr;
  logic                 w_capture;
  logic                 w_advance;

  // Next-state and capture decisions; a branch wins over every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_ir_valid_nxt = r_ir_valid;
    w_capture      = 1'b0;
    w_advance      = 1'b0;
    case (r_state)
      IDLE: begin
        if (br_valid) begin
          w_state_nxt = IDLE;
        end else if (run) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        if (br_valid) begin
          // With the ack already here there is nothing left to drain.
          w_state_nxt = mem_ack ? FETCH : DRAIN;
        end else if (mem_ack) begin
          w_capture      = 1'b1;
          w_advance      = 1'b1;
          w_ir_valid_nxt = 1'b1;
          w_state_nxt    = VALID;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // The stale request must still complete before a new one is raised.
        if (mem_ack) begin
          w_state_nxt = run ? FETCH : IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      VALID: begin
        if (br_valid || ir_ready) begin
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = run ? FETCH : IDLE;
        end else begin
          w_state_nxt = VALID;
        end
      end
      default: begin
        w_ir_valid_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  // PC steering; the PC has no enable, so hold reloads its own value.
  always_comb begin
    pc_load = 1'b1;
    pc_up   = 1'b1;
    pc_data = pc_in;
    if (br_valid) begin
      pc_data = br_target;
    end else if (w_advance) begin
      pc_load = 1'b0;
    end else begin
      pc_data = pc_in;
    end
  end

  // Memory request decode from the registered state.
  always_comb begin
    mem_req  = (r_state == FETCH) || (r_state == DRAIN);
    mem_addr = (r_state == FETCH) ? pc_in : r_addr_q;
  end

  // State, outstanding-address and instruction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr_q   <= '0;
      r_ir_valid <= 1'b0;
      r_ir_data  <= '0;
      r_ir_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      if (r_state == FETCH) begin
        r_addr_q <= pc_in;
      end
      if (w_capture) begin
        r_ir_data <= mem_rdata;
        r_ir_addr <= pc_in;
      end
    end
  end

  assign ir_valid = r_ir_valid;
  assign ir_data  = r_ir_data;
  assign ir_addr  = r_ir_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a PC model and a
// variable-latency memory responder.
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] pc_q;
  logic          pc_load;
  logic          pc_up;
  logic [AW-1:0] pc_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_rdata = 16'h0000;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [IW-1:0] ir_data;
  logic [AW-1:0] ir_addr;
  logic          br_valid = 1'b0;
  logic [AW-1:0] br_target = 8'h00;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pc_in(pc_q),
    .pc_load(pc_load), .pc_up(pc_up), .pc_data(pc_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_addr(ir_addr),
    .br_valid(br_valid), .br_target(br_target)
  );

  always #5 clk = ~clk;

  // The program counter the sequencer steers.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pc_q <= 8'h00;
    else if (pc_load) pc_q <= pc_data;
    else if (pc_up)   pc_q <= pc_q + 8'd1;
    else              pc_q <= pc_q - 8'd1;
  end

  logic [IW-1:0] mem [256];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs set by the main sequence.
  int            fixed_lat = 2;
  bit            rnd_mode = 1'b0;
  logic          run_k = 1'b0;
  logic          rdy_k = 1'b0;
  bit            br_now = 1'b0;
  bit            br_on_ack = 1'b0;
  logic [AW-1:0] br_tgt_k = 8'h00;
  int            mem_lat = 0;
  bit            mem_busy = 1'b0;

  // Memory responder and input driver, acting just after each rising edge.
  always @(posedge clk) begin
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
      end
      if (mem_lat == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        mem_busy  = 1'b0;
      end else begin
        mem_lat--;
      end
    end else begin
      mem_busy = 1'b0;
    end
    br_valid = 1'b0;
    if (rnd_mode) begin
      run      = ($urandom_range(0, 9) != 0);
      ir_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        br_valid  = 1'b1;
        br_target = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
    end else begin
      run      = run_k;
      ir_ready = rdy_k;
      if (br_now || (br_on_ack && mem_ack)) begin
        br_valid  = 1'b1;
        br_target = br_tgt_k;
        br_now    = 1'b0;
        br_on_ack = 1'b0;
      end
    end
  end

  // Scoreboard: the next word presented must come from the address the
  // program flow dictates (sequential, or the latest branch target).
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] ea;
  logic [AW-1:0] cur_a = 8'h00;
  logic          prev_valid = 1'b0;
  logic          prev_req = 1'b0;
  logic          prev_ack = 1'b0;
  logic [AW-1:0] prev_maddr = 8'h00;
  bit            draining = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_q.push_back(8'h00);
      prev_valid = 1'b0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      draining   = 1'b0;
    end else begin
      if (ir_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("ir_unexpected", 32'(ir_addr), 32'hFFFF_FFFF);
        end else begin
          ea = exp_q.pop_front();
          cur_a = ea;
          chk("ir_addr", 32'(ir_addr), 32'(ea));
          chk("ir_data", 32'(ir_data), 32'(mem[ea]));
          exp_q.push_back(ea + 8'd1);
        end
      end else if (ir_valid && prev_valid) begin
        chk("ir_hold_addr", 32'(ir_addr), 32'(cur_a));
        chk("ir_hold_data", 32'(ir_data), 32'(mem[cur_a]));
      end
      if (prev_req && !prev_ack) begin
        chk("req_held", 32'(mem_req), 32'd1);
        chk("req_addr_stable", 32'(mem_addr), 32'(prev_maddr));
      end
      if (br_valid) begin
        chk("pc_load_br", 32'(pc_load), 32'd1);
        chk("pc_data_br", 32'(pc_data), 32'(br_target));
      end else if (mem_req && mem_ack && !draining) begin
        chk("pc_adv_load", 32'(pc_load), 32'd0);
        chk("pc_adv_up", 32'(pc_up), 32'd1);
      end else begin
        chk("pc_hold_load", 32'(pc_load), 32'd1);
        chk("pc_hold_data", 32'(pc_data), 32'(pc_q));
      end
      if (mem_req && mem_ack)        draining = 1'b0;
      else if (mem_req && br_valid)  draining = 1'b1;
      if (br_valid) begin
        exp_q.delete();
        exp_q.push_back(br_target);
      end
      prev_valid = ir_valid;
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_maddr = mem_addr;
    end
  end

  task automatic wait_word(input string tag, input logic [AW-1:0] exp_a);
    logic last;
    bit   seen;
    last = ir_valid;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ir_valid && !last) seen = 1'b1;
      last = ir_valid;
    end
    if (seen) chk(tag, 32'(ir_addr), 32'(exp_a));
    else      chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_cond_br_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (br_valid && mem_ack) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && !mem_ack) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_data", 32'(ir_data), 32'd0);
    chk("rst_ir_addr", 32'(ir_addr), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd1);
    reset_n = 1'b1;

    // First fetch from 0x00 with a two-cycle memory latency, decoder stalled.
    fixed_lat = 2;
    run_k     = 1'b1;
    wait_req("t1_req");
    chk("t1_mem_addr", 32'(mem_addr), 32'h00);
    wait_word("t1_ir_addr", 8'h00);
    chk("t1_ir_data", 32'(ir_data), 32'h1234);
    chk("t1_pc_next", 32'(pc_q), 32'h01);

    // Stalled decoder: word held, no memory activity, PC held.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_ir_valid", 32'(ir_valid), 32'd1);
      chk("t2_ir_data", 32'(ir_data), 32'h1234);
      chk("t2_mem_req", 32'(mem_req), 32'd0);
      chk("t2_pc", 32'(pc_q), 32'h01);
    end

    // Branch to 0x40 while a fetch waits for its ack.
    fixed_lat = 3;
    rdy_k     = 1'b1;
    wait_req("t3_req");
    br_tgt_k = 8'h40;
    br_now   = 1'b1;
    wait_word("t3_ir_addr", 8'h40);

    // Branch in the same cycle as an ack: data dropped, PC takes the target.
    fixed_lat = 1;
    br_tgt_k  = 8'h80;
    br_on_ack = 1'b1;
    wait_cond_br_ack("t4_br");
    @(negedge clk);
    chk("t4_ir_valid", 32'(ir_valid), 32'd0);
    chk("t4_pc", 32'(pc_q), 32'h80);

    // Fetch at 0xFF then wrap to 0x00.
    br_tgt_k  = 8'hFF;
    br_on_ack = 1'b1;
    wait_cond_br_ack("t5_br");
    wait_word("t5_ir_addr_ff", 8'hFF);
    wait_word("t5_ir_addr_00", 8'h00);

    // Reset in the middle of a fetch.
    fixed_lat = 3;
    wait_req("t6_req");
    #2;
    reset_n = 1'b0;
    run_k   = 1'b0;
    #1;
    chk("t6_async_req", 32'(mem_req), 32'd0);
    chk("t6_async_valid", 32'(ir_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_idle_req", 32'(mem_req), 32'd0);
    end
    run_k = 1'b1;
    wait_word("t6_restart", 8'h00);

    // Randomized traffic against the scoreboard.
    fixed_lat = -1;
    rnd_mode  = 1'b1;
    repeat (3000) @(negedge clk);
    rnd_mode = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
